// File: rtl/uart_rx_core_if.sv
// Configuration, serial line and valid/ready result bundle shared by the UART
// receive core and whatever consumes its frames.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
);
  logic                 serialInput;
  logic [DIV_WIDTH-1:0] baudDiv;
  logic [1:0]           parityMode;
  logic                 stopBits;
  logic [DATA_BITS-1:0] dataOut;
  logic                 parityError;
  logic                 frameError;
  logic                 dataValid;
  logic                 dataReady;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  serialInput, baudDiv, parityMode, stopBits, dataReady,
    output dataOut, parityError, frameError, dataValid, overrun, busy
  );

  modport master (
    output serialInput, baudDiv, parityMode, stopBits, dataReady,
    input  dataOut, parityError, frameError, dataValid, overrun, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: line synchroniser, baud tick generator, framing
// FSM with parity/stop checking, and a small output FIFO with valid/ready.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst,
  uart_rx_core_if.slave bus
);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = DATA_BITS + 2;

  localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BI_LAST  = BIW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_line;
  logic [DIV_WIDTH-1:0] r_tickCnt;
  logic                 w_tick;

  state_t               r_state;
  logic [SCW-1:0]       r_sc;
  logic [BIW-1:0]       r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parEn;
  logic                 r_parOdd;
  logic                 r_twoStop;
  logic                 r_stopIdx;
  logic                 r_parErr;
  logic                 r_frameErr;
  logic                 r_breakWait;
  logic                 r_push;
  logic [EW-1:0]        r_pushEntry;
  logic                 r_busy;
  logic                 w_midBit;
  logic                 w_stopErr;
  logic                 w_lastStop;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wrPtr;
  logic [PW-1:0]        r_rdPtr;
  logic [CW-1:0]        r_count;
  logic [EW-1:0]        r_head;
  logic                 r_dataValid;
  logic                 r_overrun;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_write;
  logic [CW-1:0]        w_countNext;
  logic [PW-1:0]        w_rdPtrNext;
  logic [EW-1:0]        w_headNext;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.serialInput;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
  assign w_tick = (r_tickCnt == bus.baudDiv);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + DIV_WIDTH'(1);
    end
  end

  assign w_midBit   = (r_sc == SC_LAST);
  assign w_stopErr  = r_frameErr | ~w_line;
  assign w_lastStop = (r_stopIdx == r_twoStop);

  // After a low final stop bit the FSM parks in STOP until the line is seen
  // high again, so a long break yields a single errored frame.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sc        <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_parEn     <= 1'b0;
      r_parOdd    <= 1'b0;
      r_twoStop   <= 1'b0;
      r_stopIdx   <= 1'b0;
      r_parErr    <= 1'b0;
      r_frameErr  <= 1'b0;
      r_breakWait <= 1'b0;
      r_push      <= 1'b0;
      r_pushEntry <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_tick && !w_line) begin
            r_state     <= S_START;
            r_sc        <= '0;
            r_parEn     <= ^bus.parityMode;
            r_parOdd    <= bus.parityMode[1];
            r_twoStop   <= bus.stopBits;
            r_stopIdx   <= 1'b0;
            r_parErr    <= 1'b0;
            r_frameErr  <= 1'b0;
            r_breakWait <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_sc == SC_HALF) begin
              r_sc     <= '0;
              r_bitIdx <= '0;
              r_state  <= w_line ? S_IDLE : S_DATA;
            end else begin
              r_sc <= r_sc + SCW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (w_midBit) begin
              r_sc     <= '0;
              r_shift  <= {w_line, r_shift[DATA_BITS-1:1]};
              r_bitIdx <= r_bitIdx + BIW'(1);
              if (r_bitIdx == BI_LAST) begin
                r_state <= r_parEn ? S_PARITY : S_STOP;
              end
            end else begin
              r_sc <= r_sc + SCW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            if (w_midBit) begin
              r_sc     <= '0;
              r_parErr <= (^r_shift) ^ w_line ^ r_parOdd;
              r_state  <= S_STOP;
            end else begin
              r_sc <= r_sc + SCW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_breakWait) begin
              if (w_line) begin
                r_state <= S_IDLE;
              end
            end else if (w_midBit) begin
              r_sc <= '0;
              if (w_lastStop) begin
                r_push      <= 1'b1;
                r_pushEntry <= {w_stopErr, r_parErr, r_shift};
                if (w_stopErr) begin
                  r_breakWait <= 1'b1;
                end else begin
                  r_state <= S_IDLE;
                end
              end else begin
                r_frameErr <= w_stopErr;
                r_stopIdx  <= 1'b1;
              end
            end else begin
              r_sc <= r_sc + SCW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_pop       = r_dataValid & bus.dataReady;
  assign w_full      = (r_count == CNT_FULL);
  assign w_write     = r_push & (~w_full | w_pop);
  assign w_countNext = r_count + CW'(w_write) - CW'(w_pop);
  assign w_rdPtrNext = w_pop ? (r_rdPtr + PW'(1)) : r_rdPtr;
  // A frame landing in an empty (or just-emptied) FIFO bypasses storage.
  assign w_headNext  = ((r_count == CW'(0)) || ((r_count == CW'(1)) && w_pop))
                       ? r_pushEntry : r_mem[w_rdPtrNext];

  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= r_pushEntry;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_head      <= '0;
      r_dataValid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      r_rdPtr     <= w_rdPtrNext;
      r_count     <= w_countNext;
      r_dataValid <= (w_countNext != CW'(0));
      r_overrun   <= r_push & w_full & ~w_pop;
      if (w_countNext != CW'(0)) begin
        r_head <= w_headNext;
      end
    end
  end

  assign bus.dataOut     = r_head[DATA_BITS-1:0];
  assign bus.parityError = r_head[EW-2];
  assign bus.frameError  = r_head[EW-1];
  assign bus.dataValid   = r_dataValid;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = r_busy;
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core, the next generation of the fixed 8-bit receive path. It combines oversampled start-bit validation, configurable data width, runtime-selectable parity and stop-bit count, per-frame error flags, and a small output FIFO with a valid/ready handshake. It sits between the asynchronous serial pin and the consuming logic, and replaces the separate baud-generator, receive-FSM, parity-checker and output-register chain.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- OVERSAMPLE, 16: sample ticks per bit; even, at least 4.
- DIV_WIDTH, 16: width of `baudDiv`.
- FIFO_DEPTH, 4: receive FIFO entries; a power of 2, at least 2.

Ports:
- clock, input, 1: the single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- serialInput, input, 1: asynchronous serial line; idles high.
- baudDiv, input, DIV_WIDTH: one sample tick every `baudDiv+1` clocks.
- parityMode, input, 2: 00 none, 01 even, 10 odd, 11 none.
- stopBits, input, 1: 0 selects one stop bit, 1 selects two.
- dataOut, output, DATA_BITS: head-of-FIFO data.
- parityError, output, 1: head entry had a parity mismatch.
- frameError, output, 1: head entry had a low stop bit.
- dataValid, output, 1: FIFO is not empty.
- dataReady, input, 1: consumer accepts the head entry.
- overrun, output, 1: one-cycle pulse when a complete frame is dropped because the FIFO is full.
- busy, output, 1: FSM is not in IDLE.

## Operation
- **Input synchroniser.** `serialInput` passes through a 2-flop synchroniser; both flops reset to 1. All FSM decisions use the synchronised line.
- **Tick generator.** A free-running counter runs 0..`baudDiv`. The tick pulses for one clock when the count equals `baudDiv`, then the counter wraps to 0. The counter resets to 0.
- **Configuration latching.** `parityMode` and `stopBits` are latched on entry to START. Changes mid-frame do not affect the current frame. `baudDiv` is used live; it must change only while `busy` is 0.
- **IDLE.** On a tick with the line low, go to START and clear the tick counter `sc`.
- **START.** On the tick where `sc == OVERSAMPLE/2-1`, sample the line.
  - Line high: false start; return to IDLE and push nothing.
  - Line low: go to DATA with `sc` and the bit index cleared.
- **DATA.** Sample the line every OVERSAMPLE ticks, i.e. at mid-bit. Bits arrive LSB first into a shift register. After DATA_BITS samples, go to PARITY if parity is enabled, otherwise go to STOP.
- **PARITY.** Sample one bit.
  - Even mode: error if the XOR of the data bits and the parity bit is 1.
  - Odd mode: error if that XOR is 0.
- **STOP.** Sample 1 or 2 stop bits. Any low stop sample sets the frame-error flag.
  - The frame, with its flags, is pushed on the tick of the last stop sample.
  - Without a frame error: return to IDLE on that tick.
  - With a frame error: stay in STOP until a tick samples the line high, then go to IDLE. A break condition therefore produces exactly one frame.
- **FIFO entry.** Each entry is {frameError, parityError, data}. Head outputs are registered and update on the clock after a push-to-empty or a pop.
- **Pop.** An entry is popped on a clock with `dataValid && dataReady`.
- **Full FIFO.**
  - Push with no pop in the same cycle: the new frame is dropped, stored entries are untouched, and `overrun` pulses for one clock.
  - Push and pop in the same cycle: both occur, with no overrun.
- **Empty FIFO.** `dataReady` has no effect while `dataValid` is 0.
- **Pointers.** FIFO pointers wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- **Reset.** Reset in any state flushes the FIFO, returns the FSM to IDLE and discards any partial frame.

## Timing
- **Reset values.** `dataOut` = 0, `parityError` = 0, `frameError` = 0, `dataValid` = 0, `overrun` = 0, `busy` = 0.
- **Sample points.** Line to FSM is 2 clocks of synchronisation plus up to one tick of start-detect uncertainty. Samples fall OVERSAMPLE/2 ticks after start detection, then every OVERSAMPLE ticks.
- **Push to output.** `dataValid` rises on the clock after the push tick.
- **Pop to output.** After a pop, the head outputs advance and `dataValid` updates on the next edge; it drops if the FIFO becomes empty.
- **`busy`.** Rises on the clock after IDLE→START and falls on the clock after entry to IDLE.
- **Frame length.** One frame occupies `(1+DATA_BITS+P+S)·OVERSAMPLE·(baudDiv+1)` clocks, where P = 1 if parity is enabled and S = the number of stop bits.

## Test plan
All scenarios use defaults and `baudDiv` = 0, giving a 16-clock bit period.
- **Clean frame.** Drive 0xA5 with no parity and 1 stop bit. Hold `dataReady` = 0 → `dataValid` = 1, `dataOut` = 0xA5, both error flags 0. Pulse `dataReady` → `dataValid` = 0 on the next clock.
- **Parity.** Drive 0x3C in even mode with parity bit 1 → `parityError` = 1. Repeat in odd mode with parity bit 1 → `parityError` = 0.
- **Framing and break.** Drive 0x55 with a low stop bit, then hold the line low for 40 bit times → exactly one entry with `frameError` = 1. `busy` stays 1 until the line returns high.
- **Glitch rejection.** Pulse the line low for 4 clocks → no push, and `busy` returns to 0 within 2 bit times.
- **Overrun.** Send 5 frames 0x01..0x05 back-to-back with `dataReady` = 0 → `overrun` pulses once on the 5th push. Popping then yields 0x01..0x04. A full-FIFO push in the same cycle as a pop → accepted, no overrun.
- **Reset mid-frame.** Assert `rst` for 1 clock during DATA → no entry pushed, all outputs at reset values. The next frame 0x81 is received correctly.
